// File: rtl/seg7_scan.sv
// Multiplexed scan controller for a row of common-anode 7-segment digits.
// Double-buffered value/dots, swapped only at frame boundaries; optional leading-zero blanking.
module seg7_scan #(
  parameter int NDIG     = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [4*NDIG-1:0] VALUE,
  input  logic [NDIG-1:0]   DOTS,
  input  logic              LOAD,
  input  logic              BLANK_LZ,
  output logic [3:0]        DIN,
  output logic              DOT,
  output logic [NDIG-1:0]   nDIGIT,
  output logic              PENDING,
  output logic              FRAME
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NDIG);

  logic [PW-1:0]     pcnt_q,  pcnt_d;
  logic [IW-1:0]     idx_q,   idx_d;
  logic [4*NDIG-1:0] dval_q,  dval_d;
  logic [NDIG-1:0]   ddots_q, ddots_d;
  logic [4*NDIG-1:0] pval_q,  pval_d;
  logic [NDIG-1:0]   pdots_q, pdots_d;
  logic              pflag_q, pflag_d;
  logic              frame_q, frame_d;

  logic tick;
  logic boundary;

  assign tick     = (pcnt_q == PW'(SCAN_DIV - 1));
  assign boundary = tick && (idx_q == IW'(NDIG - 1));

  always_comb begin
    pcnt_d  = tick ? '0 : pcnt_q + PW'(1);
    idx_d   = idx_q;
    dval_d  = dval_q;
    ddots_d = ddots_q;
    pval_d  = pval_q;
    pdots_d = pdots_q;
    pflag_d = pflag_q;
    frame_d = boundary;
    if (tick) begin
      idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
    end
    if (boundary && pflag_q) begin
      dval_d  = pval_q;
      ddots_d = pdots_q;
      pflag_d = 1'b0;
    end
    // A load on the boundary cycle re-arms the flag after the copy took the old contents.
    if (LOAD) begin
      pval_d  = VALUE;
      pdots_d = DOTS;
      pflag_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pcnt_q  <= '0;
      idx_q   <= '0;
      dval_q  <= '0;
      ddots_q <= '0;
      pval_q  <= '0;
      pdots_q <= '0;
      pflag_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      dval_q  <= dval_d;
      ddots_q <= ddots_d;
      pval_q  <= pval_d;
      pdots_q <= pdots_d;
      pflag_q <= pflag_d;
      frame_q <= frame_d;
    end
  end

  logic [3:0]      sel_nib;
  logic            sel_dot;
  logic [NDIG-1:0] sel_oh;
  logic            upper_zero;
  logic            blank;

  always_comb begin
    sel_nib    = '0;
    sel_dot    = 1'b0;
    sel_oh     = '0;
    upper_zero = 1'b1;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (idx_q == IW'(k)) begin
        sel_nib   = dval_q[4*k +: 4];
        sel_dot   = ddots_q[k];
        sel_oh[k] = 1'b1;
      end
      if ((IW'(k) >= idx_q) && (dval_q[4*k +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    blank  = BLANK_LZ && (idx_q != '0) && upper_zero && !sel_dot;
    DIN    = blank ? 4'h0 : sel_nib;
    DOT    = blank ? 1'b0 : sel_dot;
    nDIGIT = blank ? '1 : ~sel_oh;
  end

  assign PENDING = pflag_q;
  assign FRAME   = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized plus directed bench for seg7_scan (NDIG=4, SCAN_DIV=4) against a
// cycle-count arithmetic reference model.
module tb_seg7_scan;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int FRAME_LEN = ND * SD;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] VALUE;
  logic [3:0]  DOTS;
  logic        LOAD;
  logic        BLANK_LZ;
  logic [3:0]  DIN;
  logic        DOT;
  logic [3:0]  nDIGIT;
  logic        PENDING;
  logic        FRAME;

  always #5 CLK = ~CLK;

  seg7_scan #(.NDIG(ND), .SCAN_DIV(SD)) dut (
    .CLK(CLK), .RST(RST), .VALUE(VALUE), .DOTS(DOTS), .LOAD(LOAD),
    .BLANK_LZ(BLANK_LZ), .DIN(DIN), .DOT(DOT), .nDIGIT(nDIGIT),
    .PENDING(PENDING), .FRAME(FRAME)
  );

  // Reference state: t = edges since reset release; display digit is (t/SD)%ND.
  int          t = 0;
  logic [15:0] m_disp = '0, m_pv = '0;
  logic [3:0]  m_dots = '0, m_pd = '0;
  logic        m_pf = 1'b0, m_frame = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
  endtask

  task automatic model_edge();
    if (RST) begin
      t = 0; m_disp = '0; m_dots = '0; m_pv = '0; m_pd = '0; m_pf = 1'b0; m_frame = 1'b0;
    end else begin
      bit bnd;
      bnd = ((t + 1) % FRAME_LEN) == 0;
      if (bnd && m_pf) begin
        m_disp = m_pv; m_dots = m_pd; m_pf = 1'b0;
      end
      if (LOAD) begin
        m_pv = VALUE; m_pd = DOTS; m_pf = 1'b1;
      end
      m_frame = bnd;
      t++;
    end
  endtask

  task automatic check_outputs();
    int         idx;
    logic [3:0] nib, oh, exp_n, exp_din;
    logic       dt, blank, exp_dot;
    idx   = (t / SD) % ND;
    nib   = 4'((m_disp >> (4 * idx)) & 16'hF);
    dt    = m_dots[idx];
    blank = BLANK_LZ && (idx != 0) && ((m_disp >> (4 * idx)) == 0) && !dt;
    oh    = 4'(1 << idx);
    exp_n   = blank ? 4'hF : ~oh;
    exp_din = blank ? 4'h0 : nib;
    exp_dot = blank ? 1'b0 : dt;
    chk("nDIGIT", 32'(nDIGIT), 32'(exp_n));
    chk("DIN", 32'(DIN), 32'(exp_din));
    chk("DOT", 32'(DOT), 32'(exp_dot));
    chk("PENDING", 32'(PENDING), 32'(m_pf));
    chk("FRAME", 32'(FRAME), 32'(m_frame));
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] v,
                      input logic [3:0] d, input logic b);
    RST = r; LOAD = l; VALUE = v; DOTS = d; BLANK_LZ = b;
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n, input logic b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, b);
  endtask

  task automatic advance_to_idx(input int target);
    for (int i = 0; i < 2 * FRAME_LEN && ((t / SD) % ND) != target; i++)
      step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  initial begin
    logic        blz;
    logic [15:0] v;
    logic [3:0]  d;

    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    chk("reset_nDIGIT", 32'(nDIGIT), 32'hE);
    chk("reset_PENDING", 32'(PENDING), 32'h0);

    // Scan with no load: three full frames
    run(3 * FRAME_LEN, 1'b0);

    // Basic load during digit 1
    advance_to_idx(1);
    step(1'b0, 1'b1, 16'hA3F1, 4'b0100, 1'b0);
    run(2 * FRAME_LEN, 1'b0);

    // Double buffering, including LOAD held for several cycles
    step(1'b0, 1'b1, 16'h1234, 4'h0, 1'b0);
    run(2, 1'b0);
    step(1'b0, 1'b1, 16'h9999, 4'h1, 1'b0);
    step(1'b0, 1'b1, 16'h4444, 4'h2, 1'b0);
    step(1'b0, 1'b1, 16'h5678, 4'h0, 1'b0);
    run(2 * FRAME_LEN, 1'b0);

    // LOAD exactly on the boundary cycle while 0001 is pending
    advance_to_idx(1);
    step(1'b0, 1'b1, 16'h0001, 4'h0, 1'b0);
    for (int i = 0; i < 2 * FRAME_LEN && ((t + 1) % FRAME_LEN) != 0; i++)
      step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 16'hBEEF, 4'h0, 1'b0);
    chk("bnd_load_PENDING", 32'(PENDING), 32'h1);
    chk("bnd_load_DIN", 32'(DIN), 32'h1);
    run(2 * FRAME_LEN, 1'b0);

    // Leading-zero blanking
    step(1'b0, 1'b1, 16'h0020, 4'h0, 1'b1);
    run(2 * FRAME_LEN, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 4'h0, 1'b1);
    run(2 * FRAME_LEN, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 4'b1000, 1'b1);
    run(2 * FRAME_LEN, 1'b1);

    // Reset at digit 2 with a load pending
    step(1'b0, 1'b1, 16'h7777, 4'hF, 1'b0);
    advance_to_idx(2);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    chk("midrst_PENDING", 32'(PENDING), 32'h0);
    chk("midrst_nDIGIT", 32'(nDIGIT), 32'hE);
    run(2 * FRAME_LEN, 1'b0);

    // Randomized traffic, with live BLANK_LZ flips checked mid-cycle
    blz = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 3)
        0:       v = 16'($urandom);
        1:       v = 16'($urandom % 256);
        default: v = 16'h0;
      endcase
      d = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
      if (($urandom % 50) == 0) blz = ~blz;
      step((($urandom % 500) == 0), (($urandom % 20) == 0), v, d, blz);
      if (($urandom % 10) == 0) begin
        blz = ~blz;
        BLANK_LZ = blz;
        #1;
        check_outputs();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed scan controller for a row of common-anode seven-segment digits. It holds a multi-digit hex value and walks a one-hot, active-low digit-enable across the row. Each dwell slot presents one 4-bit nibble and dot on `DIN`/`DOT`, and these feed the `SEG7DEC` decoder directly. New values are double-buffered and take effect only at a frame boundary, so a displayed frame never mixes old and new digits. Optional leading-zero blanking is included.

## Interface

Parameters:

- `NDIG`, 8: number of digits; legal range 2..16.
- `SCAN_DIV`, 50000: clock cycles per digit dwell; legal minimum is 1.

Ports:

- `CLK`  in  1  system clock.
- `RST`  in  1  reset; synchronous, active-high.
- `VALUE`  in  4*NDIG  value to show; nibble k goes to digit k, and digit 0 is the rightmost.
- `DOTS`  in  NDIG  per-digit decimal point request; 1 means lit.
- `LOAD`  in  1  one-cycle strobe that captures `VALUE`/`DOTS` into the pending buffer.
- `BLANK_LZ`  in  1  leading-zero blanking enable; it is sampled live on every cycle.
- `DIN`  out  4  nibble for the current digit; goes to the `SEG7DEC` `DIN` input.
- `DOT`  out  1  dot for the current digit; goes to the `SEG7DEC` `DOT` input.
- `nDIGIT`  out  NDIG  digit anode enables, active-low; at most one bit is low.
- `PENDING`  out  1  a loaded value is waiting for the next frame boundary.
- `FRAME`  out  1  one-cycle pulse on every frame boundary.

## Operation

- **Prescaler `pcnt`** counts 0..SCAN_DIV-1 and then wraps to 0. `tick` is asserted when `pcnt == SCAN_DIV-1`. With `SCAN_DIV = 1`, `tick` is asserted every cycle.
- **Digit index `idx`** is 0..NDIG-1 and advances on `tick`. It wraps from NDIG-1 to 0. The boundary condition is `tick && idx == NDIG-1`.
- **Pending buffer** (`pval`, `pdots`, `pflag`):
  - `LOAD` writes `VALUE`/`DOTS` into the buffer and sets `pflag`.
  - A second `LOAD` before the boundary overwrites the buffer; the last load wins.
- **Display buffer** (`dval`, `ddots`): at a boundary with `pflag` = 1, the buffer is copied from `pval`/`pdots` and `pflag` is cleared.
- **LOAD on the boundary cycle:**
  - The copy uses the pre-edge pending contents.
  - The new `VALUE` is written into the pending buffer.
  - `pflag` ends at 1, because set wins over clear.
  - The new value is shown in the following frame.
- **Outputs** are combinational from registered state (`idx`, `dval`, `ddots`, `BLANK_LZ`):
  - `DIN = dval[4*idx +: 4]`.
  - `DOT = ddots[idx]`.
  - `nDIGIT = ~(1 << idx)`.
- **Leading-zero blanking:** with `BLANK_LZ` = 1, digit `idx` is blanked when all three of these hold:
  - `idx != 0`;
  - every `dval` nibble at positions ≥ `idx` is zero;
  - `ddots[idx] == 0`.
  
  A blanked digit forces `nDIGIT` to all ones, `DIN = 0` and `DOT = 0`. Digit 0 is never blanked.
- **`FRAME`** is a registered pulse: it is high in the cycle after the boundary edge.
- **`PENDING`** equals `pflag`.

## Timing

- **Values after reset:**
  - `pcnt = 0`, `idx = 0`.
  - `dval = 0`, `ddots = 0`, `pval = 0`, `pdots = 0`, `pflag = 0`.
  - `FRAME = 0`.
  - Outputs: `DIN = 0`, `DOT = 0`, `nDIGIT` = all ones except bit 0 low, `PENDING = 0`.
- **Reset mid-frame** takes effect on the next edge. It discards any pending load, clears the display buffer, and restarts scanning at digit 0.
- **Dwell and frame:** each digit dwells exactly `SCAN_DIV` cycles, and one frame is `NDIG*SCAN_DIV` cycles.
  - Digit 0 is shown in cycles 0..SCAN_DIV-1 after reset release.
  - `idx` changes on the edge that ends the cycle with `pcnt = SCAN_DIV-1`.
- **LOAD latency:**
  - `PENDING` rises 1 cycle after the `LOAD` edge.
  - The new value appears on the edge that completes the current frame. At that same edge `idx` returns to 0, `PENDING` falls, and `FRAME` rises.
  - Worst case is `NDIG*SCAN_DIV` cycles.
- **`LOAD` held high** for multiple cycles is treated as repeated loads.
- **`BLANK_LZ` changes** take effect in the same cycle; the input is not registered.
- **No-glitch requirement:** `nDIGIT`, `DIN` and `DOT` change only on `tick` edges, display-buffer updates, or `BLANK_LZ`/reset changes. This guarantees that at most one bit of `nDIGIT` is low.

## Test plan

All scenarios use `NDIG = 4`, `SCAN_DIV = 4`.

1. **Reset and scan:** release `RST` with no load.
   - `nDIGIT` must step E, D, B, 7, E, with each value held exactly 4 cycles.
   - `DIN = 0` throughout.
   - `FRAME` must pulse every 16 cycles.
2. **Basic load:** pulse `LOAD` with `VALUE = 16'hA3F1`, `DOTS = 4'b0100` during digit 1.
   - `PENDING = 1` until the frame wraps.
   - The following frame shows `DIN` = 1, F, 3, A.
   - `DOT` = 1 only while `nDIGIT` = B.
3. **Double buffering:** `LOAD 16'h1234`, then `LOAD 16'h5678` before the boundary.
   - Only `5678` is ever shown.
   - No frame may mix old and new nibbles.
4. **LOAD on the boundary cycle:** pulse `LOAD` with `16'hBEEF` exactly on `tick && idx == 3` while `PENDING` holds `16'h0001`.
   - The next frame shows `0001`, with `PENDING` still 1.
   - The frame after shows `BEEF`.
5. **Leading-zero blanking:** set `BLANK_LZ = 1` and `VALUE = 16'h0020`.
   - Digits 3 and 2 show `nDIGIT = F`.
   - Digits 1 and 0 are driven with `DIN` = 2 and 0.
   - `VALUE = 16'h0000` shows only digit 0.
   - `DOTS[3] = 1` un-blanks digit 3.
6. **Reset mid-operation:** assert `RST` for 1 cycle at digit 2 with a load pending.
   - Next cycle: `idx = 0`, `PENDING = 0`, display shows 0.
   - Scanning then resumes with full 4-cycle dwells.
